// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, byte-addressed instruction memory with a load port,
// one big-endian word per cycle to decode over valid/ready, redirect flush and sticky fault.
module instruction_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic              fault
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        mem [MEM_DEPTH];
  logic [3:0][7:0]   word;
  logic [IDX_W-1:0]  base;
  logic              stage_free;
  logic              misaligned;
  logic              unused_load_hi;

  assign base           = pc[IDX_W-1:0];
  assign stage_free     = !out_valid || out_ready;
  assign misaligned     = redirect_target[1:0] != 2'b00;
  assign unused_load_hi = ^load_addr;

  // Byte lane 3 is the MSB (mem[a]); index arithmetic wraps at the top of memory.
  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign word[3-k] = mem[base + IDX_W'(k)];
  end

  // Memory is not reset; a write is seen by fetches from the next edge on.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_next_pc <= '0;
      fault       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid && misaligned) begin
            state     <= FAULT;
            fault     <= 1'b1;
            out_valid <= 1'b0;
          end else if (redirect_valid) begin
            // Flush the presented word even if decode is taking it this cycle.
            pc        <= redirect_target;
            out_valid <= 1'b0;
          end else if (stage_free && fetch_en) begin
            out_instr   <= word;
            out_pc      <= pc;
            out_next_pc <= pc + ADDR_W'(4);
            out_valid   <= 1'b1;
            pc          <= pc + ADDR_W'(4);
          end else if (stage_free) begin
            out_valid <= 1'b0;
          end
        end
        FAULT: begin
          out_valid <= 1'b0;
          fault     <= 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end
endmodule
